// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: owns the PC, feeds the IF/ID register and selects
// the next PC from the sequential, branch, jump and jump-register paths.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic [31:0]      addr,
  input  logic [31:0]      inst,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [15:0]      branch_imm,
  input  logic             jump_reg,
  input  logic [31:0]      jr_addr,
  input  logic             jump,
  input  logic [25:0]      jump_index,
  output logic [31:0]      ifid_inst,
  output logic [31:0]      ifid_pc4,
  output logic             ifid_valid,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [0:0]  state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] jr_target;
  logic [31:0] redirect_target;
  logic        redirect;

  assign addr     = pc;
  assign halted   = (state == ST_HALT);
  assign pc_plus4 = pc + 32'd4;

  // All targets are relative to the instruction currently in decode.
  assign branch_target = ifid_pc4 + {{14{branch_imm[15]}}, branch_imm, 2'b00};
  assign jump_target   = {ifid_pc4[31:28], jump_index, 2'b00};
  assign jr_target     = {jr_addr[31:2], 2'b00};
  assign redirect      = branch_taken | jump_reg | jump;

  always_comb begin
    // NOTE: default first so no path through this block leaves it unassigned (no latch).
    redirect_target = jump_target;
    if (branch_taken)  redirect_target = branch_target;
    else if (jump_reg) redirect_target = jr_target;
  end

  // NOTE: every register here is a small flop, so all of them take the async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: non-blocking assignments for all sequential state avoid ordering races.
      pc          <= RESET_PC;
      ifid_inst   <= '0;
      ifid_pc4    <= '0;
      ifid_valid  <= 1'b0;
      fetch_count <= '0;
      state       <= ST_RUN;
    end else if (stall) begin
      // Hold everything; a redirect seen under stall is re-asserted by ID later.
      pc          <= pc;
    end else if (redirect) begin
      pc         <= redirect_target;
      ifid_inst  <= '0;
      ifid_pc4   <= '0;
      ifid_valid <= 1'b0;
      state      <= ST_RUN;
    end else if (state == ST_HALT || inst == HALT_WORD) begin
      // The halt word itself never reaches decode; fetch parks on it.
      ifid_inst  <= '0;
      ifid_pc4   <= '0;
      ifid_valid <= 1'b0;
      state      <= ST_HALT;
    end else begin
      ifid_inst   <= inst;
      ifid_pc4    <= pc_plus4;
      ifid_valid  <= 1'b1;
      pc          <= pc_plus4;
      fetch_count <= fetch_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage with a combinational memory model.
// The DUT counter is narrowed to 4 bits so counter wrap is reachable quickly.
module tb_instruction_fetch_stage;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   addr;
  logic [31:0]   inst;
  logic          stall;
  logic          branch_taken;
  logic [15:0]   branch_imm;
  logic          jump_reg;
  logic [31:0]   jr_addr;
  logic          jump;
  logic [25:0]   jump_index;
  logic [31:0]   ifid_inst;
  logic [31:0]   ifid_pc4;
  logic          ifid_valid;
  logic          halted;
  logic [CW-1:0] fetch_count;

  logic          halt_en;
  logic [31:0]   halt_addr;
  int            n_checks = 0;
  int            n_errors = 0;

  instruction_fetch_stage #(
    .RESET_PC (32'h00000000),
    .HALT_WORD(32'hFFFFFFFF),
    .CNT_W    (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .addr        (addr),
    .inst        (inst),
    .stall       (stall),
    .branch_taken(branch_taken),
    .branch_imm  (branch_imm),
    .jump_reg    (jump_reg),
    .jr_addr     (jr_addr),
    .jump        (jump),
    .jump_index  (jump_index),
    .ifid_inst   (ifid_inst),
    .ifid_pc4    (ifid_pc4),
    .ifid_valid  (ifid_valid),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  // Memory: word at A is A|0x10000000, except an optional halt word.
  assign inst = (halt_en && addr == halt_addr) ? 32'hFFFFFFFF : (addr | 32'h10000000);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_redirects();
    branch_taken = 1'b0;
    jump_reg     = 1'b0;
    jump         = 1'b0;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] i, input logic [31:0] p4,
                            input logic v);
    check({tag, "_inst"}, ifid_inst, i);
    check({tag, "_pc4"}, ifid_pc4, p4);
    check({tag, "_valid"}, {31'd0, ifid_valid}, {31'd0, v});
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch_imm = '0; jr_addr = '0; jump_index = '0;
    halt_en = 1'b0; halt_addr = 32'h8;
    clear_redirects();
    #12;
    check("rst_addr", addr, 32'h0);
    check_ifid("rst", 32'h0, 32'h0, 1'b0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_cnt", {28'd0, fetch_count}, 32'd0);
    step();
    rst = 1'b0;

    // Sequential fetch
    check("seq_addr0", addr, 32'h0);
    step(); check("seq_addr1", addr, 32'h4);
    check_ifid("seq1", 32'h10000000, 32'h4, 1'b1);
    step(); check("seq_addr2", addr, 32'h8);
    step(); check("seq_addr3", addr, 32'hC);
    step(); check("seq_addr4", addr, 32'h10);
    check_ifid("seq4", 32'h1000000C, 32'h10, 1'b1);
    check("seq_cnt", {28'd0, fetch_count}, 32'd4);
    repeat (4) step();
    check("pre_br_pc4", ifid_pc4, 32'h20);
    check("pre_br_cnt", {28'd0, fetch_count}, 32'd8);

    // Branch redirect: 0x20 + (-4 << 2) = 0x10
    branch_taken = 1'b1; branch_imm = 16'hFFFC;
    step(); check("br_addr", addr, 32'h10);
    check("br_bubble", {31'd0, ifid_valid}, 32'd0);
    check("br_cnt", {28'd0, fetch_count}, 32'd8);
    clear_redirects();
    step(); check_ifid("br_after", 32'h10000010, 32'h14, 1'b1);
    check("br_after_cnt", {28'd0, fetch_count}, 32'd9);

    // Branch beats jump
    repeat (3) step();
    check("brj_pre_pc4", ifid_pc4, 32'h20);
    branch_taken = 1'b1; branch_imm = 16'hFFFC; jump = 1'b1; jump_index = 26'h40;
    step(); check("brj_addr", addr, 32'h10);
    check("brj_bubble", {31'd0, ifid_valid}, 32'd0);
    clear_redirects();
    step(); check("brj_after_addr", addr, 32'h14);
    check_ifid("brj_after", 32'h10000010, 32'h14, 1'b1);
    check("brj_cnt", {28'd0, fetch_count}, 32'd13);

    // Stall overrides a pending jump
    stall = 1'b1; jump = 1'b1; jump_index = 26'h40;
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_addr", addr, 32'h14);
      check_ifid("stall", 32'h10000010, 32'h14, 1'b1);
      check("stall_cnt", {28'd0, fetch_count}, 32'd13);
    end
    stall = 1'b0;
    step(); check("unstall_jump_addr", addr, 32'h100);
    check("unstall_bubble", {31'd0, ifid_valid}, 32'd0);
    check("unstall_cnt", {28'd0, fetch_count}, 32'd13);
    clear_redirects();

    // Halt on the word at 0x8
    halt_en = 1'b1;
    jump_reg = 1'b1; jr_addr = 32'h0;
    step(); check("jr0_addr", addr, 32'h0);
    clear_redirects();
    step(); check("h_addr4", addr, 32'h4);
    step(); check("h_addr8", addr, 32'h8);
    check_ifid("h_pre", 32'h10000004, 32'h8, 1'b1);
    check("h_cnt_ones", {28'd0, fetch_count}, 32'd15);
    for (int k = 0; k < 3; k++) begin
      step();
      check("halt_flag", {31'd0, halted}, 32'd1);
      check("halt_addr", addr, 32'h8);
      check("halt_bubble", {31'd0, ifid_valid}, 32'd0);
    end
    check("halt_cnt", {28'd0, fetch_count}, 32'd15);
    jump_reg = 1'b1; jr_addr = 32'h43;
    step(); check("resume_addr", addr, 32'h40);
    check("resume_halted", {31'd0, halted}, 32'd0);
    clear_redirects();
    step(); check_ifid("resume", 32'h10000040, 32'h44, 1'b1);
    check("cnt_wrap", {28'd0, fetch_count}, 32'd0);

    // PC wrap
    jump_reg = 1'b1; jr_addr = 32'hFFFFFFFF;
    step(); check("wrap_pre_addr", addr, 32'hFFFFFFFC);
    clear_redirects();
    step(); check("wrap_addr", addr, 32'h0);
    check_ifid("wrap", 32'hFFFFFFFC, 32'h0, 1'b1);
    check("wrap_cnt", {28'd0, fetch_count}, 32'd1);

    // Async reset while halted with a redirect pending
    step(); step(); step();
    check("ar_halted", {31'd0, halted}, 32'd1);
    check("ar_addr", addr, 32'h8);
    jump = 1'b1; jump_index = 26'h40;
    #2; rst = 1'b1;
    #1;
    check("ar_addr_rst", addr, 32'h0);
    check("ar_halted_rst", {31'd0, halted}, 32'd0);
    check_ifid("ar", 32'h0, 32'h0, 1'b0);
    check("ar_cnt", {28'd0, fetch_count}, 32'd0);
    clear_redirects();
    step();
    rst = 1'b0;
    step(); check("post_rst_addr", addr, 32'h4);
    check_ifid("post_rst", 32'h10000000, 32'h4, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- Front end of the pipelined CPU. Owns the program counter and drives the instruction address into InstructionMemory.
- Captures the returned instruction into the IF/ID pipeline register and resolves next-PC selection among sequential, branch, jump and jump-register.
- Applies stall and flush requests coming from the hazard logic.
- Detects a halt word: it freezes fetch until a redirect arrives.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.
HALT_WORD, 32'hFFFFFFFF, instruction encoding that halts fetch.
CNT_W, 32, width of the fetched-instruction counter.

Ports:
Clk  in  1  clock, rising-edge.
Rst  in  1  asynchronous active-high reset.
Addr  out  32  instruction address to InstructionMemory; equals the PC register.
Inst  in  32  instruction word from InstructionMemory; a combinational function of Addr, valid in the same cycle.
Stall  in  1  hold PC and IF/ID (load-use hazard from ID).
BranchTaken  in  1  ID-stage branch resolved taken.
BranchImm  in  16  ID-stage branch immediate.
JumpReg  in  1  ID-stage jr.
JrAddr  in  32  register target for jr.
Jump  in  1  ID-stage j/jal.
JumpIndex  in  26  instr_index field of the jump.
IFID_Inst  out  32  registered instruction to decode.
IFID_PC4  out  32  registered PC+4 of that instruction.
IFID_Valid  out  1  IF/ID holds a real instruction (0 = bubble).
Halted  out  1  fetch frozen on HALT_WORD.
FetchCount  out  CNT_W  count of instructions accepted into IF/ID.

Behaviour:
- Reset (asynchronous, any time, including mid-redirect or mid-halt) sets:
  - PC=RESET_PC
  - IFID_Inst=0, IFID_PC4=0, IFID_Valid=0
  - Halted=0, FetchCount=0
  - state=RUN
- States are RUN and HALT. Halted=1 exactly in HALT.
- Targets are computed from the IF/ID contents (the ID-stage instruction):
  - branch = IFID_PC4 + (sign_extend(BranchImm) << 2), mod 2^32.
  - jump = {IFID_PC4[31:28], JumpIndex, 2'b00}.
  - jr = {JrAddr[31:2], 2'b00}. Low bits are forced to zero, so Addr[1:0] is always 00.
- Redirect request = BranchTaken | JumpReg | Jump. Target priority is branch > jr > jump.
- Per rising edge, highest priority first:
  1. Stall=1: PC, IF/ID, FetchCount and state all hold. Redirect inputs are ignored that cycle; the source re-asserts them.
  2. Redirect: PC<=target. IF/ID<=bubble (Inst=0, PC4=0, Valid=0). FetchCount unchanged. state<=RUN, which also exits HALT.
  3. HALT: PC holds; IF/ID<=bubble.
  4. RUN with Inst==HALT_WORD: PC holds; IF/ID<=bubble; state<=HALT. The halt word is never passed to decode.
  5. RUN normal: IFID_Inst<=Inst, IFID_PC4<=PC+4, IFID_Valid<=1, PC<=PC+4, FetchCount<=FetchCount+1.
- Arithmetic wrap:
  - PC+4 wraps mod 2^32 (32'hFFFFFFFC -> 0).
  - FetchCount wraps mod 2^CNT_W.
- Latency: an instruction at Addr appears on IFID_Inst one edge later. Fetch throughput is one per cycle when unstalled.
- Redirect penalty: exactly one bubble (the wrong-path fetch in the redirect cycle is discarded).
- The first fetch after reset release is from RESET_PC. IFID_Valid goes high at the first edge after release.

Test Plan:
- Sequential fetch: release reset, memory returns Inst=Addr|32'h10000000, 4 edges. Required: Addr sequence 0,4,8,C,10; IFID_Inst=32'h1000000C with IFID_PC4=32'h10; FetchCount=4.
- Branch redirect: IF/ID holds PC4=32'h20, BranchTaken=1, BranchImm=16'hFFFC. Required: next Addr=32'h10, one bubble (IFID_Valid=0), then Inst@0x10 latched. Repeat with Jump=1 also asserted: branch still wins.
- Stall/redirect conflict: Stall=1 for 3 cycles with Jump=1 and JumpIndex=26'h40. Required: Addr, IFID_* and FetchCount frozen and jump ignored. On the cycle Stall drops with Jump still 1: Addr=32'h100.
- Halt: Inst=32'hFFFFFFFF at Addr=32'h8. Required: Halted=1 next edge, Addr stays 8 and IFID_Valid=0 indefinitely. JumpReg=1 with JrAddr=32'h43 then gives Addr=32'h40, Halted=0, and fetch resumes.
- Wrap: force PC to 32'hFFFFFFFC via jr, run 1 edge. Required: Addr=0, IFID_PC4=0. Separately, preload FetchCount to all ones and fetch once: FetchCount=0.
- Async reset mid-operation: assert Rst between clock edges during HALT with a redirect pending. Required: outputs reach reset values immediately, without waiting for a clock edge, and Addr=RESET_PC.
